// File: rtl/alu_writeback_buffer.sv
// Two-entry result buffer between the ALU and the register-file write port.
// Optional divide-by-zero flagging is enabled by defining ALU_WB_DIVZERO_CHECK_EN.
module alu_writeback_buffer #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_WIDTH   = 6,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [OPCODE_WIDTH-1:0]   inOpCode,
    input  logic [DATA_WIDTH-1:0]     inOperand2,
    input  logic [DATA_WIDTH-1:0]     inResult,
    input  logic [REG_ADDR_WIDTH-1:0] inDestReg,
    output logic                      outValid,
    input  logic                      outReady,
    output logic [DATA_WIDTH-1:0]     outResult,
    output logic [REG_ADDR_WIDTH-1:0] outDestReg,
    output logic                      outZero,
    output logic                      outNegative,
    output logic                      outDivByZero,
    output logic [1:0]                occupancy,
    output logic [COUNT_WIDTH-1:0]    retiredCount
);

    logic [1:0][DATA_WIDTH-1:0]     entryResult;
    logic [1:0][REG_ADDR_WIDTH-1:0] entryDest;
    logic [1:0]                     entryZero;
    logic [1:0]                     entryNegative;

    logic [1:0] count;
    logic       wrPtr;
    logic       rdPtr;
    logic       push;
    logic       pop;

    logic [DATA_WIDTH-1:0] capResult;
    logic                  capDivByZero;
    logic                  capZero;
    logic                  capNegative;

`ifdef ALU_WB_DIVZERO_CHECK_EN
    localparam logic [OPCODE_WIDTH-1:0] OP_DIV = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_MOD = OPCODE_WIDTH'(4);

    logic [1:0] entryDivByZero;

    // A faulting divide is replaced by all-ones so the flags below follow naturally.
    always_comb begin
        capDivByZero = ((inOpCode == OP_DIV) || (inOpCode == OP_MOD)) && (inOperand2 == '0);
        capResult    = capDivByZero ? '1 : inResult;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entryDivByZero <= '0;
        end else if (push) begin
            entryDivByZero[wrPtr] <= capDivByZero;
        end
    end

    assign outDivByZero = entryDivByZero[rdPtr];
`else
    logic unusedCheckInputs;

    assign unusedCheckInputs = ^{inOpCode, inOperand2};
    assign capDivByZero      = 1'b0;
    assign capResult         = inResult;
    assign outDivByZero      = 1'b0;
`endif

    assign capZero     = (capResult == '0);
    assign capNegative = capResult[DATA_WIDTH-1];

    // Handshake qualifiers come only from registered count, never from the opposite side.
    assign inReady  = (count != 2'd2);
    assign outValid = (count != 2'd0);
    assign push     = inValid && inReady;
    assign pop      = outValid && outReady;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entryResult   <= '0;
            entryDest     <= '0;
            entryZero     <= '0;
            entryNegative <= '0;
            wrPtr         <= 1'b0;
            rdPtr         <= 1'b0;
            count         <= 2'd0;
            retiredCount  <= '0;
        end else begin
            if (push) begin
                entryResult[wrPtr]   <= capResult;
                entryDest[wrPtr]     <= inDestReg;
                entryZero[wrPtr]     <= capZero;
                entryNegative[wrPtr] <= capNegative;
                wrPtr                <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
                if (retiredCount != '1) begin
                    retiredCount <= retiredCount + COUNT_WIDTH'(1);
                end
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign outResult   = entryResult[rdPtr];
    assign outDestReg  = entryDest[rdPtr];
    assign outZero     = entryZero[rdPtr];
    assign outNegative = entryNegative[rdPtr];
    assign occupancy   = count;

endmodule

// File: tb/tb_alu_writeback_buffer.sv
// Scoreboard bench for alu_writeback_buffer: driver queues expected entries, monitor checks pops.
module tb_alu_writeback_buffer;

    localparam int RET_MAX = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [5:0]  inOpCode;
    logic [31:0] inOperand2;
    logic [31:0] inResult;
    logic [4:0]  inDestReg;
    logic        outValid;
    logic        outReady;
    logic [31:0] outResult;
    logic [4:0]  outDestReg;
    logic        outZero;
    logic        outNegative;
    logic        outDivByZero;
    logic [1:0]  occupancy;
    logic [1:0]  retiredCount;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  dest;
        logic        z;
        logic        n;
        logic        d;
    } exp_t;

    exp_t q[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   expRetired = 0;

    alu_writeback_buffer #(
        .DATA_WIDTH(32), .OPCODE_WIDTH(6), .REG_ADDR_WIDTH(5), .COUNT_WIDTH(2)
    ) dut (
        .clock(clock), .reset(reset),
        .inValid(inValid), .inReady(inReady), .inOpCode(inOpCode),
        .inOperand2(inOperand2), .inResult(inResult), .inDestReg(inDestReg),
        .outValid(outValid), .outReady(outReady), .outResult(outResult),
        .outDestReg(outDestReg), .outZero(outZero), .outNegative(outNegative),
        .outDivByZero(outDivByZero), .occupancy(occupancy), .retiredCount(retiredCount)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] op, input logic [31:0] o2,
                                   input logic [31:0] res, input logic [4:0] dst);
        exp_t m;
        m.res  = res;
        m.dest = dst;
        m.d    = 1'b0;
`ifdef ALU_WB_DIVZERO_CHECK_EN
        if ((op == 6'd3 || op == 6'd4) && o2 == 32'd0) begin
            m.d   = 1'b1;
            m.res = 32'hFFFF_FFFF;
        end
`endif
        m.z = (m.res == 32'd0);
        m.n = m.res[31];
        return m;
    endfunction

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input logic v, input logic [5:0] op, input logic [31:0] o2,
                        input logic [31:0] res, input logic [4:0] dst, input logic rdy,
                        output logic acc);
        inValid    = v;
        inOpCode   = op;
        inOperand2 = o2;
        inResult   = res;
        inDestReg  = dst;
        outReady   = rdy;
        #2;
        acc = v && inReady;
        if (acc) q.push_back(model(op, o2, res, dst));
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (reset) begin
            chk("retiredCount", 32'(retiredCount), 32'(expRetired));
            if (outValid && outReady) begin
                if (q.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL unexpected_pop: got outResult 0x%0h expected no entry", outResult);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("outResult", outResult, e.res);
                    chk("outDestReg", 32'(outDestReg), 32'(e.dest));
                    chk("outZero", 32'(outZero), 32'(e.z));
                    chk("outNegative", 32'(outNegative), 32'(e.n));
                    chk("outDivByZero", 32'(outDivByZero), 32'(e.d));
                end
                expRetired = (expRetired == RET_MAX) ? RET_MAX : expRetired + 1;
            end
        end
    end

    initial begin
        logic acc;
        reset      = 1'b0;
        inValid    = 1'b0;
        inOpCode   = '0;
        inOperand2 = '0;
        inResult   = '0;
        inDestReg  = '0;
        outReady   = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rst_outValid", 32'(outValid), 32'd0);
        chk("rst_outResult", outResult, 32'd0);
        chk("rst_outDestReg", 32'(outDestReg), 32'd0);
        chk("rst_flags", 32'({outZero, outNegative, outDivByZero}), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_inReady", 32'(inReady), 32'd1);
        chk("rst_retired", 32'(retiredCount), 32'd0);
        reset = 1'b1;

        // single push with one-cycle latency
        step(1'b1, 6'd0, 32'd0, 32'd5, 5'd3, 1'b1, acc);
        chk("t1_outValid", 32'(outValid), 32'd1);
        chk("t1_outResult", outResult, 32'd5);
        chk("t1_outDestReg", 32'(outDestReg), 32'd3);
        chk("t1_outZero", 32'(outZero), 32'd0);
        step(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
        chk("t1_outValid_after", 32'(outValid), 32'd0);
        chk("t1_retired", 32'(retiredCount), 32'd1);

        // fill while stalled; third push must be refused
        step(1'b1, 6'd0, 32'd0, 32'h10, 5'd1, 1'b0, acc);
        step(1'b1, 6'd0, 32'd0, 32'h20, 5'd2, 1'b0, acc);
        step(1'b1, 6'd0, 32'd0, 32'h30, 5'd3, 1'b0, acc);
        chk("t2_third_accepted", 32'(acc), 32'd0);
        chk("t2_occupancy", 32'(occupancy), 32'd2);
        chk("t2_inReady", 32'(inReady), 32'd0);
        step(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
        step(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
        chk("t2_occupancy_drained", 32'(occupancy), 32'd0);

        // zero and negative flags
        step(1'b1, 6'd0, 32'd0, 32'd0, 5'd4, 1'b1, acc);
        chk("t3_outZero", 32'(outZero), 32'd1);
        step(1'b1, 6'd0, 32'd0, 32'h8000_0000, 5'd5, 1'b1, acc);
        chk("t3_outNegative", 32'(outNegative), 32'd1);
        step(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);

        // divide-by-zero detection
        step(1'b1, 6'd3, 32'd0, 32'd7, 5'd6, 1'b1, acc);
`ifdef ALU_WB_DIVZERO_CHECK_EN
        chk("t4_dbz", 32'(outDivByZero), 32'd1);
        chk("t4_dbz_result", outResult, 32'hFFFF_FFFF);
`else
        chk("t4_dbz", 32'(outDivByZero), 32'd0);
        chk("t4_dbz_result", outResult, 32'd7);
`endif
        step(1'b1, 6'd3, 32'd2, 32'd3, 5'd7, 1'b1, acc);
        chk("t4_nodbz", 32'(outDivByZero), 32'd0);
        step(1'b1, 6'd4, 32'd0, 32'd9, 5'd8, 1'b1, acc);
        step(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);

        // simultaneous push and pop at count 1, then async reset mid-stream
        step(1'b1, 6'd0, 32'd0, 32'h1, 5'd9, 1'b0, acc);
        step(1'b1, 6'd0, 32'd0, 32'hA, 5'd10, 1'b1, acc);
        chk("t5_occupancy", 32'(occupancy), 32'd1);
        chk("t5_head", outResult, 32'hA);
        step(1'b1, 6'd0, 32'd0, 32'hB, 5'd11, 1'b0, acc);
        chk("t5_occupancy_full", 32'(occupancy), 32'd2);
        reset = 1'b0;
        #1;
        chk("t5_rst_outValid", 32'(outValid), 32'd0);
        chk("t5_rst_occupancy", 32'(occupancy), 32'd0);
        chk("t5_rst_retired", 32'(retiredCount), 32'd0);
        chk("t5_rst_outResult", outResult, 32'd0);
        q.delete();
        expRetired = 0;
        inValid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;

        // retired counter saturation with a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 6'd0, 32'd0, 32'h100 + 32'(i), 5'(i), 1'b1, acc);
        end
        step(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
        step(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
        chk("t6_retired_sat", 32'(retiredCount), 32'd3);
        chk("t6_occupancy", 32'(occupancy), 32'd0);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/alu_writeback_buffer.md
# alu_writeback_buffer

Two-entry result buffer directly downstream of the combinational ALU. Captures each ALU result with its destination register tag, derives status flags, and presents them to the register-file write port over a valid/ready handshake. Lets the write side stall without losing results. Counts retired results for debug.

## Interface

**Parameters**
- DATA_WIDTH, 32, ALU result and operand width
- OPCODE_WIDTH, 6, ALU opcode width
- REG_ADDR_WIDTH, 5, destination register tag width
- COUNT_WIDTH, 16, retired-result counter width

**Ports**
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately when low
- inValid  input  1  ALU result valid this cycle
- inReady  output  1  buffer can accept; high when occupancy < 2
- inOpCode  input  OPCODE_WIDTH  opcode that produced inResult
- inOperand2  input  DATA_WIDTH  second ALU operand, used for divide-by-zero detection
- inResult  input  DATA_WIDTH  ALU outputData
- inDestReg  input  REG_ADDR_WIDTH  destination register tag
- outValid  output  1  head entry valid
- outReady  input  1  write port accepts head entry
- outResult  output  DATA_WIDTH  head result
- outDestReg  output  REG_ADDR_WIDTH  head destination tag
- outZero  output  1  head result == 0
- outNegative  output  1  head result MSB
- outDivByZero  output  1  head entry came from DIV/MOD with zero divisor
- occupancy  output  2  entries held, 0..2
- retiredCount  output  COUNT_WIDTH  output handshakes since reset, saturating

## Operation

- Storage: 2-entry circular FIFO, 1-bit write/read pointers, 2-bit count register.
- Push when inValid && inReady; pop when outValid && outReady.
- inReady = (count != 2); depends only on registered count, no combinational path from outReady.
- outValid = (count != 0); out* fields driven from the head entry register, no combinational path from in*.
- Flags computed at capture and stored per entry: zero = (result == 0); negative = result[DATA_WIDTH-1]; divByZero per Configuration.
- Opcode encodings: DIV = 3, MOD = 4.
- Simultaneous push and pop at count 1: count stays 1, new entry becomes head next cycle.
- Simultaneous push and pop at count 0: impossible (outValid low); push only.
- At count 2: inReady low; a pop that cycle does not enable a push until the next cycle.
- retiredCount increments by 1 per pop; holds at all-ones once reached.
- Data in unoccupied entries is don't-care; out* data fields are don't-care while outValid low, except at reset.

## Timing

- Reset (reset low): count, pointers, all entries, retiredCount cleared to 0; outValid 0, outResult 0, outDestReg 0, all flags 0, occupancy 0, inReady 1. Takes effect asynchronously; release is synchronous to the next rising edge.
- Reset mid-operation discards all held entries; no partial pop is reported.
- Latency: input accepted at edge N is visible on out* with outValid high after edge N (1 cycle) when buffer was empty.
- Throughput: 1 result/cycle sustained while outReady held high.
- occupancy equals count, updated on the same edge as push/pop.

## Configuration

- Macro ALU_WB_DIVZERO_CHECK_EN.
- Defined: divByZero = (inOpCode == 3 || inOpCode == 4) && (inOperand2 == 0); when set, stored result forced to all-ones, zero flag 0, negative flag 1.
- Undefined: outDivByZero constant 0; inResult stored unchanged; inOperand2 unused.

## Test plan

- Reset then single push inResult=5, inDestReg=3, outReady=1 -> next cycle outValid=1, outResult=5, outDestReg=3, outZero=0; following cycle outValid=0, retiredCount=1.
- outReady=0, push 0x10, 0x20, 0x30 back-to-back -> third not accepted (inReady=0 after two), occupancy=2; release outReady -> outputs 0x10 then 0x20 in order.
- Push inResult=0 then 0x80000000 -> outZero=1 on first, outNegative=1 on second.
- With ALU_WB_DIVZERO_CHECK_EN: inOpCode=3, inOperand2=0 -> outDivByZero=1, outResult=0xFFFFFFFF; inOpCode=3, inOperand2=2 -> outDivByZero=0. Without macro: outDivByZero=0 for both.
- Count=1, simultaneous push 0xA and pop -> occupancy stays 1, next head 0xA; assert reset low mid-stream -> outValid=0, occupancy=0, retiredCount=0 immediately.
- COUNT_WIDTH=2, perform 5 pops -> retiredCount saturates at 3.
